// File: rtl/enemy_scheduler.sv
// rtl/enemy_scheduler.sv - per-frame enemy sequencer; optional DRAW timeout under ENEMY_SCHED_TIMEOUT_EN
module enemy_scheduler #(
    parameter int NUM_ENEMIES  = 4,
    parameter int IDX_W        = 2,
    parameter int MOVE_DIV     = 4
`ifdef ENEMY_SCHED_TIMEOUT_EN
    ,
    parameter int DRAW_TIMEOUT = 300
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic [NUM_ENEMIES-1:0] enemy_alive,
    input  logic [NUM_ENEMIES-1:0] draw_done,
    output logic [NUM_ENEMIES-1:0] init,
    output logic                   idle,
    output logic [NUM_ENEMIES-1:0] gen_move,
    output logic [NUM_ENEMIES-1:0] move_enemies,
    output logic [NUM_ENEMIES-1:0] draw_enemies,
    output logic [IDX_W-1:0]       enemy_sel,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_overrun
`ifdef ENEMY_SCHED_TIMEOUT_EN
    ,
    output logic                   draw_timeout
`endif
);

    typedef enum logic [2:0] {
        WAIT_START,
        INIT,
        IDLE,
        CHECK,
        GEN,
        MOVE,
        DRAW,
        DONE
    } state_t;

    localparam int                     MCNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [MCNT_W-1:0]      MCNT_LAST = MCNT_W'(MOVE_DIV - 1);
    localparam logic [IDX_W-1:0]       SEL_LAST  = IDX_W'(NUM_ENEMIES - 1);
    localparam logic [NUM_ENEMIES-1:0] ONE       = NUM_ENEMIES'(1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         sel_q, sel_d;
    logic [MCNT_W-1:0]        mcnt_q, mcnt_d;
    logic                     move_frame_q, move_frame_d;
    logic [NUM_ENEMIES-1:0]   init_q, init_d;
    logic                     idle_q, idle_d;
    logic [NUM_ENEMIES-1:0]   gen_move_q, gen_move_d;
    logic [NUM_ENEMIES-1:0]   move_enemies_q, move_enemies_d;
    logic [NUM_ENEMIES-1:0]   draw_enemies_q, draw_enemies_d;
    logic                     busy_q, busy_d;
    logic                     frame_done_q, frame_done_d;
    logic                     frame_overrun_q, frame_overrun_d;
    logic                     draw_exit;

`ifdef ENEMY_SCHED_TIMEOUT_EN
    localparam int                TCNT_W    = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DRAW_TIMEOUT - 1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              draw_timeout_q, draw_timeout_d;
`endif

    // Next-state sequencing plus registered output decode from the upcoming state and index
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        mcnt_d          = mcnt_q;
        move_frame_d    = move_frame_q;
        frame_overrun_d = 1'b0;
        draw_exit       = 1'b0;
`ifdef ENEMY_SCHED_TIMEOUT_EN
        tcnt_d          = tcnt_q;
        draw_timeout_d  = 1'b0;
`endif

        case (state_q)
            WAIT_START: begin
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                mcnt_d  = '0;
                state_d = IDLE;
            end
            IDLE: begin
                if (frame_tick) begin
                    sel_d        = '0;
                    move_frame_d = (mcnt_q == MCNT_LAST);
                    mcnt_d       = (mcnt_q == MCNT_LAST) ? '0 : mcnt_q + MCNT_W'(1);
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (enemy_alive[sel_q]) begin
                    state_d = move_frame_q ? GEN : DRAW;
                end else if (sel_q == SEL_LAST) begin
                    state_d = DONE;
                end else begin
                    sel_d = sel_q + IDX_W'(1);
                end
            end
            GEN: begin
                state_d = MOVE;
            end
            MOVE: begin
                state_d = DRAW;
            end
            DRAW: begin
                draw_exit = draw_done[sel_q];
`ifdef ENEMY_SCHED_TIMEOUT_EN
                tcnt_d = tcnt_q + TCNT_W'(1);
                if (!draw_done[sel_q] && (tcnt_q == TCNT_LAST)) begin
                    draw_exit      = 1'b1;
                    draw_timeout_d = 1'b1;
                end
`endif
                if (draw_exit) begin
                    if (sel_q == SEL_LAST) begin
                        state_d = DONE;
                    end else begin
                        sel_d   = sel_q + IDX_W'(1);
                        state_d = CHECK;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = WAIT_START;
            end
        endcase

        // A tick while the frame is still being serviced is flagged and dropped
        if (frame_tick && (state_q != WAIT_START) && (state_q != IDLE) && (state_q != INIT)) begin
            frame_overrun_d = 1'b1;
        end

`ifdef ENEMY_SCHED_TIMEOUT_EN
        if ((state_d == DRAW) && (state_q != DRAW)) begin
            tcnt_d = '0;
        end
`endif

        init_d         = (state_d == INIT) ? '1 : '0;
        idle_d         = (state_d == IDLE);
        gen_move_d     = (state_d == GEN)  ? (ONE << sel_d) : '0;
        move_enemies_d = (state_d == MOVE) ? (ONE << sel_d) : '0;
        draw_enemies_d = (state_d == DRAW) ? (ONE << sel_d) : '0;
        busy_d         = (state_d != WAIT_START) && (state_d != IDLE);
        frame_done_d   = (state_d == DONE);
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= WAIT_START;
            sel_q           <= '0;
            mcnt_q          <= '0;
            move_frame_q    <= 1'b0;
            init_q          <= '0;
            idle_q          <= 1'b0;
            gen_move_q      <= '0;
            move_enemies_q  <= '0;
            draw_enemies_q  <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
`ifdef ENEMY_SCHED_TIMEOUT_EN
            tcnt_q          <= '0;
            draw_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            mcnt_q          <= mcnt_d;
            move_frame_q    <= move_frame_d;
            init_q          <= init_d;
            idle_q          <= idle_d;
            gen_move_q      <= gen_move_d;
            move_enemies_q  <= move_enemies_d;
            draw_enemies_q  <= draw_enemies_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            frame_overrun_q <= frame_overrun_d;
`ifdef ENEMY_SCHED_TIMEOUT_EN
            tcnt_q          <= tcnt_d;
            draw_timeout_q  <= draw_timeout_d;
`endif
        end
    end

    assign init          = init_q;
    assign idle          = idle_q;
    assign gen_move      = gen_move_q;
    assign move_enemies  = move_enemies_q;
    assign draw_enemies  = draw_enemies_q;
    assign enemy_sel     = sel_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_overrun = frame_overrun_q;
`ifdef ENEMY_SCHED_TIMEOUT_EN
    assign draw_timeout  = draw_timeout_q;
`endif

endmodule

// File: tb/tb_enemy_scheduler.sv
// tb/tb_enemy_scheduler.sv - scoreboard bench for enemy_scheduler
`timescale 1ns/1ps
module tb_enemy_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] enemy_alive = 4'b0;
    logic [3:0] draw_done = 4'b0;
    logic [3:0] init, gen_move, move_enemies, draw_enemies;
    logic       idle, busy, frame_done, frame_overrun;
    logic [1:0] enemy_sel;
`ifdef ENEMY_SCHED_TIMEOUT_EN
    logic       draw_timeout;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] idx;
        logic [3:0] vec;
    } ev_t;

    localparam logic [1:0] K_GEN  = 2'd0;
    localparam logic [1:0] K_MOVE = 2'd1;
    localparam logic [1:0] K_DRAW = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    ev_t        e_exp;
    ev_t        e_obs;
    logic [3:0] prev_draw = 4'b0;
    int         draw_delay = 3;
    logic [3:0] noise_mask = 4'b0;
    int         model_mcnt = 0;
    int         ovr_seen = 0;
    int         done_seen = 0;
    int         tmo_seen = 0;
    logic       resp_active = 1'b0;
    int         resp_cnt = 0;
    logic [3:0] resp_vec = 4'b0;

    always #5 clock = ~clock;

    enemy_scheduler #(
        .NUM_ENEMIES (4),
        .IDX_W       (2),
        .MOVE_DIV    (4)
`ifdef ENEMY_SCHED_TIMEOUT_EN
        ,
        .DRAW_TIMEOUT(300)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .frame_tick   (frame_tick),
        .enemy_alive  (enemy_alive),
        .draw_done    (draw_done),
        .init         (init),
        .idle         (idle),
        .gen_move     (gen_move),
        .move_enemies (move_enemies),
        .draw_enemies (draw_enemies),
        .enemy_sel    (enemy_sel),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_overrun(frame_overrun)
`ifdef ENEMY_SCHED_TIMEOUT_EN
        ,
        .draw_timeout (draw_timeout)
`endif
    );

    // Monitor: turns strobe activity into events and compares them with the scoreboard
    always @(negedge clock) begin
        obs_q.delete();
        if (reset !== 1'b1) begin
            if (gen_move != 4'b0)     obs_q.push_back({K_GEN, enemy_sel, gen_move});
            if (move_enemies != 4'b0) obs_q.push_back({K_MOVE, enemy_sel, move_enemies});
            if (draw_enemies != 4'b0 && prev_draw == 4'b0)
                obs_q.push_back({K_DRAW, enemy_sel, draw_enemies});
            if (frame_done === 1'b1) begin
                obs_q.push_back({K_DONE, 2'b0, 4'b0});
                done_seen++;
            end
            if (frame_overrun === 1'b1) ovr_seen++;
`ifdef ENEMY_SCHED_TIMEOUT_EN
            if (draw_timeout === 1'b1) tmo_seen++;
`endif
        end
        prev_draw = draw_enemies;
        while (obs_q.size() > 0) begin
            e_obs = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got kind=%0d sel=%0d vec=%b, required no event",
                         e_obs.kind, e_obs.idx, e_obs.vec);
            end else begin
                e_exp = exp_q.pop_front();
                if (e_obs !== e_exp) begin
                    errors++;
                    $display("FAIL scoreboard_event: got kind=%0d sel=%0d vec=%b, required kind=%0d sel=%0d vec=%b",
                             e_obs.kind, e_obs.idx, e_obs.vec, e_exp.kind, e_exp.idx, e_exp.vec);
                end
            end
        end
    end

    // Enemy model: answers draw_done draw_delay cycles after draw_enemies rises; 0 means never
    initial begin
        forever begin
            @(negedge clock);
            draw_done = noise_mask;
            if (reset) begin
                resp_active = 1'b0;
            end else if (!resp_active && draw_enemies != 4'b0) begin
                resp_active = 1'b1;
                resp_cnt    = 0;
                resp_vec    = draw_enemies;
            end else if (resp_active) begin
                if (draw_enemies == 4'b0) begin
                    resp_active = 1'b0;
                end else begin
                    resp_cnt++;
                    if (draw_delay != 0 && resp_cnt == draw_delay) draw_done = noise_mask | resp_vec;
                end
            end
        end
    end

    // Pushes the expected events of one frame from the bench's own mcnt model
    task automatic push_frame(input logic [3:0] alive, output int alive_cnt, output bit mv);
        alive_cnt = 0;
        mv = (model_mcnt == 3);
        model_mcnt = mv ? 0 : model_mcnt + 1;
        for (int i = 0; i < 4; i++) begin
            if (alive[i]) begin
                alive_cnt++;
                if (mv) begin
                    exp_q.push_back({K_GEN, 2'(i), 4'(1 << i)});
                    exp_q.push_back({K_MOVE, 2'(i), 4'(1 << i)});
                end
                exp_q.push_back({K_DRAW, 2'(i), 4'(1 << i)});
            end
        end
        exp_q.push_back({K_DONE, 2'b0, 4'b0});
    endtask

    task automatic do_frame(input logic [3:0] alive, input int delay, input logic [3:0] noise, input string name);
        int  alive_cnt;
        bit  mv;
        int  k;
        int  n;
        int  exp_n;
        push_frame(alive, alive_cnt, mv);
        k = (delay == 0) ? 300 : delay + 1;
        exp_n = 4 + alive_cnt * (k + (mv ? 2 : 0)) + 1;
        @(negedge clock);
        enemy_alive = alive;
        draw_delay  = delay;
        noise_mask  = noise;
        frame_tick  = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        n = 1;
        while (frame_done !== 1'b1 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles tick->frame_done, required %0d", name, n, exp_n);
        end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_end_state: got frame_done=%b idle=%b, required 0 1", name, frame_done, idle);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events: got %0d unconsumed, required 0", name, exp_q.size());
        end
        noise_mask = 4'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if ({init, gen_move, move_enemies, draw_enemies} !== 16'h0 || enemy_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_vectors: got %h sel=%0d, required 0000 sel=0",
                     {init, gen_move, move_enemies, draw_enemies}, enemy_sel);
        end
        checks++;
        if ({idle, busy, frame_done, frame_overrun} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000", {idle, busy, frame_done, frame_overrun});
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({idle, busy, init} !== 6'b0) begin
            errors++;
            $display("FAIL wait_start_idle: got idle=%b busy=%b init=%b, required 0 0 0000", idle, busy, init);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (init !== 4'b1111 || busy !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL init_pulse: got init=%b busy=%b idle=%b, required 1111 1 0", init, busy, idle);
        end
        @(negedge clock);
        checks++;
        if (init !== 4'b0 || idle !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_init: got init=%b idle=%b busy=%b, required 0000 1 0", init, idle, busy);
        end
        model_mcnt = 0;
    endtask

    task automatic test_move_cadence;
        for (int f = 1; f <= 4; f++) do_frame(4'b1111, 256, 4'b0, $sformatf("cadence_f%0d", f));
    endtask

    task automatic test_sparse;
        do_frame(4'b1010, 3, 4'b0101, "sparse");
    endtask

    task automatic test_all_dead;
        int alive_cnt;
        bit mv;
        int n;
        int d0;
        push_frame(4'b0000, alive_cnt, mv);
        d0 = done_seen;
        @(negedge clock);
        enemy_alive = 4'b0000;
        frame_tick  = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        n = 1;
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL dead_latency: got %0d, required 5", n);
        end
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        checks++;
        if (frame_overrun !== 1'b1) begin
            errors++;
            $display("FAIL tick_on_done_overrun: got %b, required 1", frame_overrun);
        end
        repeat (8) @(negedge clock);
        checks++;
        if (done_seen - d0 !== 1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL tick_on_done_dropped: got %0d done pulses idle=%b, required 1 1", done_seen - d0, idle);
        end
    endtask

    task automatic test_overrun;
        int alive_cnt;
        bit mv;
        int n;
        int o0;
        push_frame(4'b1111, alive_cnt, mv);
        o0 = ovr_seen;
        @(negedge clock);
        enemy_alive = 4'b1111;
        draw_delay  = 20;
        frame_tick  = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        n = 0;
        while (!(enemy_sel === 2'd1 && draw_enemies === 4'b0010) && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL overrun_reach_draw1: got sel=%0d draw=%b, required 1 0010", enemy_sel, draw_enemies);
        end
        frame_tick = 1'b1;
        start      = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        start      = 1'b0;
        checks++;
        if (frame_overrun !== 1'b1 || enemy_sel !== 2'd1 || draw_enemies !== 4'b0010 || init !== 4'b0) begin
            errors++;
            $display("FAIL overrun_pulse: got ovr=%b sel=%0d draw=%b init=%b, required 1 1 0010 0000",
                     frame_overrun, enemy_sel, draw_enemies, init);
        end
        @(negedge clock);
        checks++;
        if (frame_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_one_cycle: got %b, required 0", frame_overrun);
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checks++;
        if (ovr_seen - o0 !== 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_frame: got %0d overruns %0d pending, required 1 0", ovr_seen - o0, exp_q.size());
        end
        do_frame(4'b1111, 3, 4'b0, "post_overrun");
    endtask

    task automatic test_reset_mid_draw;
        int alive_cnt;
        bit mv;
        int n;
        int d0;
        int o0;
        push_frame(4'b1111, alive_cnt, mv);
        @(negedge clock);
        enemy_alive = 4'b1111;
        draw_delay  = 50;
        frame_tick  = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        n = 0;
        while (!(enemy_sel === 2'd2 && draw_enemies === 4'b0100) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL mid_reach_draw2: got sel=%0d draw=%b, required 2 0100", enemy_sel, draw_enemies);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({init, gen_move, move_enemies, draw_enemies} !== 16'h0 || enemy_sel !== 2'd0 ||
            {idle, busy, frame_done} !== 3'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got vec=%h sel=%0d flags=%b, required 0000 0 000",
                     {init, gen_move, move_enemies, draw_enemies}, enemy_sel, {idle, busy, frame_done});
        end
        exp_q.delete();
        reset = 1'b0;
        d0 = done_seen;
        o0 = ovr_seen;
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        repeat (8) @(negedge clock);
        checks++;
        if (idle !== 1'b0 || busy !== 1'b0 || done_seen != d0 || ovr_seen != o0) begin
            errors++;
            $display("FAIL mid_reset_wait_start: got idle=%b busy=%b done=%0d ovr=%0d, required 0 0 0 0",
                     idle, busy, done_seen - d0, ovr_seen - o0);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (init !== 4'b1111) begin
            errors++;
            $display("FAIL restart_init: got %b, required 1111", init);
        end
        model_mcnt = 0;
        @(negedge clock);
        do_frame(4'b0100, 2, 4'b0, "restart");
    endtask

`ifdef ENEMY_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int t0;
        t0 = tmo_seen;
        do_frame(4'b0011, 0, 4'b0, "timeout");
        checks++;
        if (tmo_seen - t0 !== 2) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, required 2", tmo_seen - t0);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_move_cadence;
        test_sparse;
        test_all_dead;
        test_overrun;
        test_reset_mid_draw;
`ifdef ENEMY_SCHED_TIMEOUT_EN
        test_timeout;
`endif
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
